// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Boot and arbitration controller for the single-cycle core's instruction
// memory. A program image arrives over a valid/ready load stream and is written
// word-sequentially from index 0. While loading, the core is held stalled;
// once the image is complete (last beat, or memory full) the core is released
// and its fetches are serviced with alignment/range checking. A run-time
// reload request halts the core and restarts the load sequence.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   ld_valid     in   load beat valid
//   ld_data      in   load beat instruction word
//   ld_last      in   final beat of the image
//   ld_ready     out  controller accepts a beat this cycle
//   reload_req   in   single-cycle pulse: halt core and reload (RUN only)
//   core_run     out  core may advance its PC
//   load_ovf     out  sticky: image was longer than DEPTH words
//   load_count   out  words written by the last/current load (saturates)
//   fetch_req    in   core fetch request
//   fetch_addr   in   byte address from the PC
//   fetch_rvalid out  fetch result valid, one cycle after the grant
//   fetch_err    out  with fetch_rvalid: misaligned or out-of-range address
//   fetch_instr  out  instruction returned to the core
//   imem_we      out  memory write enable
//   imem_waddr   out  memory write word index
//   imem_wdata   out  memory write data
//   imem_raddr   out  memory read word index
//   imem_rdata   in   memory read data, combinational from imem_raddr
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload_req,
    output logic              core_run,
    output logic              load_ovf,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_rvalid,
    output logic              fetch_err,
    output logic [31:0]       fetch_instr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-1:0] imem_raddr,
    input  logic [31:0]       imem_rdata
);

    // Word count as a value of the counter's own width.
    localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_SLOT_W = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t            state_r;
    // The write pointer and the reported word count always advance together,
    // so one register serves both; it is one bit wider than an index so that
    // a completely full memory reads back as DEPTH.
    logic [ADDR_W:0]   wptr_r;
    logic              load_ovf_r;
    logic              fetch_rvalid_r;
    logic              fetch_err_r;
    logic [31:0]       fetch_instr_r;

    logic              ld_ready_s;
    logic              beat_s;
    logic              last_slot_s;
    logic              grant_s;
    logic              fetch_bad_s;

    // A fetch is rejected when it is not word aligned or lies beyond the last
    // word of the memory (any address bit above the index field set).
    function automatic logic fetch_is_bad(input logic [31:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = |addr[31:ADDR_W+2];
        return misaligned | out_of_range;
    endfunction

    // Saturating increment of the load counter.
    function automatic logic [ADDR_W:0] count_inc(input logic [ADDR_W:0] cnt);
        logic [ADDR_W:0] nxt;
        if (cnt >= DEPTH_W) begin
            nxt = DEPTH_W;
        end else begin
            nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Handshake, fetch-grant and address decode for the current cycle.
    always_comb begin
        ld_ready_s  = 1'b0;
        beat_s      = 1'b0;
        last_slot_s = 1'b0;
        grant_s     = 1'b0;
        fetch_bad_s = 1'b0;
        if (state_r == ST_LOAD) begin
            ld_ready_s = (wptr_r < DEPTH_W);
        end else begin
            ld_ready_s = 1'b0;
        end
        beat_s      = ld_valid & ld_ready_s;
        last_slot_s = (wptr_r == LAST_SLOT_W);
        // A reload in the same cycle takes priority and the fetch is dropped.
        if (state_r == ST_RUN) begin
            grant_s = fetch_req & ~reload_req;
        end else begin
            grant_s = 1'b0;
        end
        fetch_bad_s = fetch_is_bad(fetch_addr);
    end

    // Memory-side and core-side outputs that must respond in the same cycle:
    // the write follows the handshake and the read address follows the fetch
    // because the memory returns data combinationally.
    always_comb begin
        ld_ready   = ld_ready_s;
        imem_we    = beat_s;
        imem_waddr = {ADDR_W{1'b0}};
        imem_wdata = 32'h0000_0000;
        imem_raddr = {ADDR_W{1'b0}};
        core_run   = 1'b0;
        if (beat_s) begin
            imem_waddr = wptr_r[ADDR_W-1:0];
            imem_wdata = ld_data;
        end else begin
            imem_waddr = {ADDR_W{1'b0}};
            imem_wdata = 32'h0000_0000;
        end
        if (grant_s) begin
            imem_raddr = fetch_addr[ADDR_W+1:2];
        end else begin
            imem_raddr = {ADDR_W{1'b0}};
        end
        // The core is stopped in the very cycle the reload is requested so
        // that it does not advance past the instruction being replaced.
        if (state_r == ST_RUN) begin
            core_run = ~reload_req;
        end else begin
            core_run = 1'b0;
        end
    end

    // Boot sequencer: IDLE -> LOAD -> DONE -> RUN, with RUN -> LOAD on reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wptr_r     <= {(ADDR_W + 1){1'b0}};
            load_ovf_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // The first valid only opens the load; that beat is taken
                    // on a later cycle once ld_ready is up.
                    if (ld_valid) begin
                        state_r    <= ST_LOAD;
                        wptr_r     <= {(ADDR_W + 1){1'b0}};
                        load_ovf_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        wptr_r <= count_inc(wptr_r);
                        if (ld_last) begin
                            state_r <= ST_DONE;
                        end else if (last_slot_s) begin
                            // Memory is full and the image is still going:
                            // flag it and stop accepting beats.
                            load_ovf_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (reload_req) begin
                        state_r    <= ST_LOAD;
                        wptr_r     <= {(ADDR_W + 1){1'b0}};
                        load_ovf_r <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wptr_r     <= {(ADDR_W + 1){1'b0}};
                    load_ovf_r <= 1'b0;
                end
            endcase
        end
    end

    // Fetch response stage: captures the memory word (or the NOP substitute on
    // a bad address) one cycle after the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_rvalid_r <= 1'b0;
            fetch_err_r    <= 1'b0;
            fetch_instr_r  <= 32'h0000_0000;
        end else begin
            fetch_rvalid_r <= grant_s;
            if (grant_s) begin
                fetch_err_r <= fetch_bad_s;
                if (fetch_bad_s) begin
                    fetch_instr_r <= NOP_WORD;
                end else begin
                    fetch_instr_r <= imem_rdata;
                end
            end else begin
                fetch_err_r   <= 1'b0;
                fetch_instr_r <= fetch_instr_r;
            end
        end
    end

    assign load_ovf     = load_ovf_r;
    assign load_count   = wptr_r;
    assign fetch_rvalid = fetch_rvalid_r;
    assign fetch_err    = fetch_err_r;
    assign fetch_instr  = fetch_instr_r;

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot and arbitration controller for the single-cycle core's 64-word instruction memory.
- Accepts a program image over a valid/ready load stream and writes it word-sequentially into the memory.
- Holds the core stalled while loading, then releases it and services core fetches with address checking.
- Supports reload at run time: the core is halted, the memory is rewritten, then the core is released again.

Parameters:
DEPTH, 64, number of 32-bit instruction words
ADDR_W, 6, word-index width (log2 DEPTH)
NOP_WORD, 32'h00000013, instruction driven on a fetch error (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ld_valid  input  1  load beat valid
ld_data  input  32  load beat instruction word
ld_last  input  1  final beat of image
ld_ready  output  1  controller accepts beat
reload_req  input  1  single-cycle pulse: halt core and reload
core_run  output  1  core may advance its PC
load_ovf  output  1  sticky: image exceeded DEPTH words
load_count  output  ADDR_W+1  words written by the last/current load
fetch_req  input  1  core fetch request
fetch_addr  input  32  byte address from PC
fetch_rvalid  output  1  fetch result valid, one cycle after grant
fetch_err  output  1  with fetch_rvalid: misaligned or out-of-range
fetch_instr  output  32  instruction returned to core
imem_we  output  1  memory write enable
imem_waddr  output  ADDR_W  memory write word index
imem_wdata  output  32  memory write data
imem_raddr  output  ADDR_W  memory read word index
imem_rdata  input  32  memory read data, combinational from imem_raddr

Behaviour:
- Reset (async):
  - State IDLE.
  - Outputs: ld_ready=0, core_run=0, load_ovf=0, load_count=0, fetch_rvalid=0, fetch_err=0, fetch_instr=0, imem_we=0, imem_waddr=0, imem_wdata=0, imem_raddr=0.
  - Memory contents are not touched.
- States: IDLE, LOAD, DONE, RUN.
- IDLE:
  - ld_ready=0.
  - ld_valid=1 moves to LOAD next cycle, with wptr=0 and load_count=0. The beat is not consumed.
- LOAD:
  - ld_ready=1 while wptr<DEPTH.
  - Each beat with ld_valid&ld_ready drives imem_we=1, imem_waddr=wptr, imem_wdata=ld_data in the same cycle (combinational from the handshake).
  - On each such beat, wptr and load_count increment at the clock edge.
  - Beat with ld_last=1 moves to DONE.
  - Beat written at wptr=DEPTH-1 without ld_last: set load_ovf and move to DONE; ld_ready is low from then on, and further beats are not accepted.
  - A beat with ld_last at DEPTH-1 is a normal finish and does not set load_ovf.
- DONE:
  - One cycle, ld_ready=0, imem_we=0; then RUN.
- RUN:
  - core_run=1 and ld_ready=0.
  - Fetch: when fetch_req=1, imem_raddr=fetch_addr[ADDR_W+1:2].
  - Next cycle fetch_rvalid=1 with fetch_instr=registered imem_rdata.
  - Error case: if fetch_addr[1:0]!=0 or fetch_addr>=DEPTH*4, fetch_err=1 and fetch_instr=NOP_WORD.
  - When fetch_req=0, fetch_rvalid=0 next cycle.
- reload_req in RUN:
  - core_run drops in the same cycle (combinational).
  - Next state LOAD with wptr=0, load_count=0, load_ovf cleared.
  - A fetch requested in that cycle is not granted: fetch_rvalid=0 next cycle.
  - ld_valid in that cycle is ignored.
- reload_req outside RUN: ignored.
- Reset mid-load: returns to IDLE. Partially written words remain in memory; load_count=0.
- load_count saturates at DEPTH. It holds its value in DONE/RUN.

Test Plan:
- Load 12 words (0x00000000, 0x019806B3, ..., 0x00948663, last on 12th) with ld_valid held high → 12 writes to indices 0..11 on consecutive cycles; load_count=12; DONE one cycle; core_run=1; load_ovf=0.
- In RUN, fetch_addr=0x4 → next cycle fetch_rvalid=1, fetch_instr=0x019806B3, fetch_err=0. fetch_addr=0x2 → fetch_err=1, fetch_instr=0x00000013. fetch_addr=0x100 → fetch_err=1.
- Stream 70 words without ld_last → exactly 64 writes; load_ovf=1; load_count=64; ld_ready=0 after the 64th beat; RUN entered.
- ld_valid toggling 1,0,1,0 with ld_last on the 3rd accepted beat → writes only on handshake cycles to indices 0,1,2; load_count=3.
- In RUN, reload_req coincident with fetch_req → core_run=0 the same cycle; no fetch_rvalid; new 2-word load overwrites indices 0..1; core_run=1 again after DONE.
- Assert reset after 5 beats of a load → all outputs at reset values immediately; state IDLE; next ld_valid starts a load at index 0.
